// File: rtl/fracnet_div_pkg.sv
// Shared constants and state encoding for the FracNet sequential divider.
package fracnet_div_pkg;

    localparam int DIVIDEND_W = 28;
    localparam int DIVISOR_W  = 12;
    localparam int QUOT_W     = 16;
    localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/fracnet_div_fixup.sv
// Sign restoration, overflow detection and quotient saturation/wrap for the divider.
// FRACNET_DIV_SAT_EN selects clamping of overflowed quotients instead of wrapping.
module fracnet_div_fixup #(
    parameter int DIVIDEND_W = fracnet_div_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = fracnet_div_pkg::DIVISOR_W,
    parameter int QUOT_W     = fracnet_div_pkg::QUOT_W
) (
    input  logic [DIVIDEND_W-1:0]       i_q_mag,
    input  logic [DIVISOR_W-1:0]        i_r_mag,
    input  logic                        i_sign_n,
    input  logic                        i_sign_d,
    input  logic                        i_dbz,
    output logic signed [QUOT_W-1:0]    o_quot,
    output logic signed [DIVISOR_W-1:0] o_rem,
    output logic                        o_ovf
);

    localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((64'd1 << (QUOT_W - 1)) - 64'd1);
    localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(64'd1 << (QUOT_W - 1));
    localparam logic signed [QUOT_W-1:0] Q_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic signed [QUOT_W-1:0] Q_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

    function automatic logic signed [QUOT_W-1:0] clamp(input logic neg);
        return neg ? Q_MIN : Q_MAX;
    endfunction

    logic w_neg;

    always_comb begin
        w_neg  = i_sign_n ^ i_sign_d;
        // A negative result may reach one step further than a positive one.
        o_ovf  = w_neg ? (i_q_mag > NEG_LIM) : (i_q_mag > POS_LIM);
        o_quot = QUOT_W'(w_neg ? -i_q_mag : i_q_mag);
        o_rem  = DIVISOR_W'(i_sign_n ? -i_r_mag : i_r_mag);
`ifdef FRACNET_DIV_SAT_EN
        if (o_ovf) begin
            o_quot = clamp(w_neg);
        end
`endif
        if (i_dbz) begin
            o_quot = clamp(i_sign_n);
            o_rem  = '0;
            o_ovf  = 1'b0;
        end
    end

endmodule

// File: rtl/fracnet_t_div_seq.sv
// Radix-2 restoring signed divider, one quotient bit per cycle, valid/ready on both sides.
// FRACNET_DIV_SAT_EN (in fracnet_div_fixup) clamps overflowed quotients instead of wrapping.
module fracnet_t_div_seq #(
    parameter int DIVIDEND_W = fracnet_div_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = fracnet_div_pkg::DIVISOR_W,
    parameter int QUOT_W     = fracnet_div_pkg::QUOT_W
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIVIDEND_W-1:0] dividend,
    input  logic signed [DIVISOR_W-1:0]  divisor,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [QUOT_W-1:0]     quotient,
    output logic signed [DIVISOR_W-1:0]  remainder,
    output logic                         ovf,
    output logic                         dbz
);
    import fracnet_div_pkg::*;

    localparam int CNT_BITS = $clog2(DIVIDEND_W + 1);

    div_state_t            r_state;
    logic [CNT_BITS-1:0]   r_cnt;
    logic                  r_dbz;
    logic                  r_sign_n;
    logic                  r_sign_d;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_mag_d;
    logic [DIVISOR_W-1:0]  r_rem;

    logic [DIVIDEND_W-1:0]       w_mag_n;
    logic [DIVISOR_W-1:0]        w_mag_d;
    logic [DIVISOR_W:0]          w_shift;
    logic                        w_ge;
    logic [DIVISOR_W-1:0]        w_rem_next;
    logic [DIVIDEND_W-1:0]       w_dvd_next;
    logic signed [QUOT_W-1:0]    w_fix_q;
    logic signed [DIVISOR_W-1:0] w_fix_r;
    logic                        w_fix_ovf;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    assign w_mag_n = dividend[DIVIDEND_W-1] ? $unsigned(-dividend) : $unsigned(dividend);
    assign w_mag_d = divisor[DIVISOR_W-1]   ? $unsigned(-divisor)  : $unsigned(divisor);

    // r_dvd shifts the dividend magnitude out of its MSB while quotient bits fill its LSB.
    assign w_shift    = {r_rem, r_dvd[DIVIDEND_W-1]};
    assign w_ge       = w_shift[DIVISOR_W] | (w_shift[DIVISOR_W-1:0] >= r_mag_d);
    assign w_rem_next = w_ge ? (w_shift[DIVISOR_W-1:0] - r_mag_d) : w_shift[DIVISOR_W-1:0];
    assign w_dvd_next = {r_dvd[DIVIDEND_W-2:0], w_ge};

    fracnet_div_fixup #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W),
        .QUOT_W     (QUOT_W)
    ) u_fixup (
        .i_q_mag  (w_dvd_next),
        .i_r_mag  (w_rem_next),
        .i_sign_n (r_sign_n),
        .i_sign_d (r_sign_d),
        .i_dbz    (r_dbz),
        .o_quot   (w_fix_q),
        .o_rem    (w_fix_r),
        .o_ovf    (w_fix_ovf)
    );

    // Control and result registers; a zero divisor spends one CALC cycle and skips iteration.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dbz     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= CALC;
                        r_cnt   <= '0;
                        r_dbz   <= (divisor == '0);
                    end
                end
                CALC: begin
                    if (r_dbz || (r_cnt == CNT_BITS'(DIVIDEND_W - 1))) begin
                        r_state   <= DONE;
                        quotient  <= w_fix_q;
                        remainder <= w_fix_r;
                        ovf       <= w_fix_ovf;
                        dbz       <= r_dbz;
                    end else begin
                        r_cnt <= r_cnt + CNT_BITS'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded before use.
    always_ff @(posedge ap_clk) begin
        if (r_state == IDLE && in_valid) begin
            r_sign_n <= dividend[DIVIDEND_W-1];
            r_sign_d <= divisor[DIVISOR_W-1];
            r_dvd    <= w_mag_n;
            r_mag_d  <= w_mag_d;
            r_rem    <= '0;
        end else if (r_state == CALC) begin
            r_dvd <= w_dvd_next;
            r_rem <= w_rem_next;
        end
    end

endmodule
